// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the Wallace multiplier, the MAC accumulator and
// the result consumer. The master drives commands and products; the slave is the accumulator.
interface mac_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] product;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             busy;

  modport master (
    output start, len, in_valid, product, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, product, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/mac_accumulator.sv
// Accumulation stage of the Wallace MAC: sums len unsigned products through a
// Brent-Kung prefix adder and returns the result with a sticky carry-out flag.
module mac_accumulator #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  mac_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int top_pow2(input int n);
    int t;
    t = 1;
    while (t * 2 < n) t = t * 2;
    return t;
  endfunction

  localparam int BK_TOP = top_pow2(WIDTH);

  // Brent-Kung prefix: up-sweep builds group carries at 2^k-1, down-sweep fills the gaps.
  function automatic logic [WIDTH:0] bk_add(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             cin);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p0;
    g    = a & b;
    p    = a ^ b;
    p0   = p;
    g[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = BK_TOP; d > 0; d = d / 2) begin
      for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    return {g[WIDTH-1], p0 ^ {g[WIDTH-2:0], cin}};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [LEN_W-1:0] r_count;
  logic             r_ovf;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;

  assign w_accept = bus.in_valid && (r_state == S_ACCUM);

  always_comb begin
    w_sum = bk_add(r_acc, bus.product, 1'b0);
  end

  // NOTE: every state register uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= bus.len;
            r_state <= (bus.len == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum[WIDTH-1:0];
            r_ovf   <= r_ovf | w_sum[WIDTH];
            r_count <= r_count - LEN_W'(1);
            if (r_count == LEN_W'(1)) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_ACCUM);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign bus.result    = r_acc;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: hand-computed sums, overflow, bubbles,
// zero length, output back-pressure, mid-run reset and maximum length.
module tb_mac_accumulator;

  localparam int WIDTH = 32;
  localparam int LEN_W = 8;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   exp_sum;

  mac_accumulator_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  mac_accumulator #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_len(input logic [LEN_W-1:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    tick();
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  task automatic push(input logic v, input logic [WIDTH-1:0] p);
    bus.in_valid = v;
    bus.product  = p;
    tick();
    bus.in_valid = 1'b0;
    bus.product  = '0;
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.product   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    bus.result,             32'd0);
    check("rst_overflow",  {31'd0, bus.overflow},  32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);

    // len=4, products 1..4 back to back
    start_len(8'd4);
    check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t1_busy",     {31'd0, bus.busy},     32'd1);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) check("t1_not_done_early", {31'd0, bus.out_valid}, 32'd0);
      push(1'b1, WIDTH'(k));
    end
    check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_result",    bus.result,             32'd10);
    check("t1_overflow",  {31'd0, bus.overflow},  32'd0);
    tick();
    bus.out_ready = 1'b0;
    check("t1_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t1_idle_busy",      {31'd0, bus.busy},      32'd0);

    // len=3 with bubbles: valid 1,0,0,1,0,1
    start_len(8'd3);
    push(1'b1, 32'h10);
    push(1'b0, 32'hDEAD);
    push(1'b0, 32'hDEAD);
    push(1'b1, 32'h20);
    push(1'b0, 32'hDEAD);
    check("t2_still_accum", {31'd0, bus.in_ready}, 32'd1);
    push(1'b1, 32'h30);
    check("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t2_result",    bus.result,             32'h60);

    // held in DONE: start and products must be ignored
    bus.start    = 1'b1;
    bus.len      = 8'd7;
    bus.in_valid = 1'b1;
    bus.product  = 32'h1234;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_hold_result",    bus.result,             32'h60);
      check("t5_hold_overflow",  {31'd0, bus.overflow},  32'd0);
      check("t5_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("t5_hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
    end
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.product  = '0;
    ack();
    check("t5_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t5_idle_busy",      {31'd0, bus.busy},      32'd0);

    // overflow: 0xFFFFFFFF + 2 wraps to 1 with carry-out
    start_len(8'd2);
    push(1'b1, 32'hFFFF_FFFF);
    push(1'b1, 32'h0000_0002);
    check("t3_result",   bus.result,            32'h1);
    check("t3_overflow", {31'd0, bus.overflow}, 32'd1);
    ack();
    check("t3_sticky_in_idle", {31'd0, bus.overflow}, 32'd1);
    start_len(8'd1);
    check("t3_ovf_cleared", {31'd0, bus.overflow}, 32'd0);
    push(1'b1, 32'd5);
    check("t3b_result",   bus.result,            32'd5);
    check("t3b_overflow", {31'd0, bus.overflow}, 32'd0);
    ack();

    // len=0 goes straight to DONE
    start_len(8'd0);
    check("t4_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t4_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("t4_result",    bus.result,             32'd0);
    check("t4_overflow",  {31'd0, bus.overflow},  32'd0);
    ack();

    // reset mid-accumulation discards the partial sum
    start_len(8'd4);
    push(1'b1, 32'd100);
    push(1'b1, 32'd200);
    check("t6_partial", bus.result, 32'd300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("t6_rst_result",    bus.result,             32'd0);
    check("t6_rst_overflow",  {31'd0, bus.overflow},  32'd0);
    check("t6_rst_busy",      {31'd0, bus.busy},      32'd0);
    start_len(8'd2);
    push(1'b1, 32'd7);
    push(1'b1, 32'd8);
    check("t6_new_result", bus.result, 32'd15);
    ack();

    // maximum length 255: products 1..255, sum 32640
    start_len(8'd255);
    exp_sum = 0;
    for (int k = 1; k <= 255; k++) begin
      if (k == 255) check("t7_not_done_early", {31'd0, bus.out_valid}, 32'd0);
      push(1'b1, WIDTH'(k));
      exp_sum += k;
    end
    check("t7_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t7_result",    bus.result,             32'd32640);
    check("t7_overflow",  {31'd0, bus.overflow},  32'd0);
    ack();
    check("t7_idle", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
